// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
//
// Registered interrupt/event arbiter front-end. Request lines are folded into
// a pending register (edge- or level-triggered), masked, and one eligible
// request is selected. The selected index is offered on a valid/ready
// handshake and held stable until the consumer takes it.
//
// Parameters
//   N           number of request lines (2..64)
//   IDX_W       index width, must equal $clog2(N)
//   ROUND_ROBIN 0: lowest eligible index wins
//               1: search starts just after the last granted index
//   EDGE        1: a rising edge on REQ sets pending
//               0: a high REQ sets pending every cycle
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous reset, active high
//   REQ        in   [N]     request lines, synchronous to CLK
//   MASK       in   [N]     1 excludes the line from selection (still pends)
//   CLEAR_ALL  in           synchronous clear of every pending bit
//   READY      in           consumer accepts the offered index
//   VALID      out          INDEX is offered
//   INDEX      out  [IDX_W] offered request index
//   PENDING    out  [N]     pending register
//
// Handshake: VALID/INDEX come straight from flops. Once VALID rises, INDEX
// stays unchanged until the cycle in which VALID && READY is sampled on a
// rising CLK edge (or CLEAR_ALL withdraws the offer). VALID always drops for
// at least one cycle after a grant. READY is ignored while VALID is low.
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter int N           = 16,
  parameter int IDX_W       = 4,
  parameter int ROUND_ROBIN = 0,
  parameter int EDGE        = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     REQ,
  input  logic [N-1:0]     MASK,
  input  logic             CLEAR_ALL,
  input  logic             READY,
  output logic             VALID,
  output logic [IDX_W-1:0] INDEX,
  output logic [N-1:0]     PENDING
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     req_q, req_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [N-1:0]     set_vec;
  logic [N-1:0]     elig;
  logic [N-1:0]     grant_clr;
  logic [N-1:0]     above_last;
  logic [N-1:0]     elig_hi;
  logic [IDX_W-1:0] pick_fixed;
  logic [IDX_W-1:0] pick_rr;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;

  // Lowest set bit of v; zero when v is empty (callers only use the result
  // when v has at least one bit set).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) res = IDX_W'(k);
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Request capture and pending register
  // -------------------------------------------------------------------------
  always_comb begin
    req_d = REQ;
    if (EDGE != 0) set_vec = REQ & ~req_q;
    else           set_vec = REQ;
  end

  assign accept    = (state_q == ST_OFFER) && READY;
  assign grant_clr = accept ? (N'(1) << index_q) : '0;

  // Priority per bit: clear-all, then set, then grant clear. Applying the set
  // after the grant clear keeps a bit pending when it re-arrives in the very
  // cycle it is granted.
  always_comb begin
    pending_d = pending_q;
    if (CLEAR_ALL) pending_d = '0;
    else           pending_d = (pending_q & ~grant_clr) | set_vec;
  end

  // -------------------------------------------------------------------------
  // Selection
  // -------------------------------------------------------------------------
  assign elig       = pending_q & ~MASK;
  assign pick_fixed = lowest_set(elig);

  // Round-robin: prefer eligible bits strictly above the last grant, else
  // wrap to the lowest eligible bit. When last_q == N-1 the shift overflows
  // to zero, so above_last is empty and the search wraps to index 0.
  assign above_last = ~((N'(2) << last_q) - N'(1));
  assign elig_hi    = elig & above_last;
  assign pick_rr    = (elig_hi != '0) ? lowest_set(elig_hi) : lowest_set(elig);

  assign pick_idx   = (ROUND_ROBIN != 0) ? pick_rr : pick_fixed;

  // -------------------------------------------------------------------------
  // Offer FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((elig != '0) && !CLEAR_ALL) begin
          state_d = ST_OFFER;
          index_d = pick_idx;
        end
      end
      ST_OFFER: begin
        // A grant taken together with CLEAR_ALL still advances the pointer.
        if (READY) last_d = index_q;
        if (READY || CLEAR_ALL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      index_q   <= '0;
      last_q    <= IDX_W'(N - 1);
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      index_q   <= index_d;
      last_q    <= last_d;
    end
  end

  assign VALID   = (state_q == ST_OFFER);
  assign INDEX   = index_q;
  assign PENDING = pending_q;

  // -------------------------------------------------------------------------
  // Interface properties
  // -------------------------------------------------------------------------
  a_index_in_range: assert property (@(posedge CLK) disable iff (RESET)
    VALID |-> (int'(INDEX) < N));

  a_offer_held: assert property (@(posedge CLK) disable iff (RESET)
    (VALID && !READY && !CLEAR_ALL) |=> (VALID && $stable(INDEX)));

  a_gap_after_offer: assert property (@(posedge CLK) disable iff (RESET)
    (VALID && (READY || CLEAR_ALL)) |=> !VALID);

  a_offer_is_pending: assert property (@(posedge CLK) disable iff (RESET)
    VALID |-> ((PENDING & (N'(1) << INDEX)) != '0));

endmodule

// File: tb/tb_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_irq_priority_encoder
//
// Four arbiter configurations share one set of stimulus lines:
//   inst 0: N=16 fixed priority, edge
//   inst 1: N=16 round robin,    edge
//   inst 2: N=16 fixed priority, level
//   inst 3: N=5  round robin,    level (non power-of-two wrap)
// Each instance has its own reference model that is advanced once per clock
// and compared against VALID/INDEX/PENDING on every falling edge. Directed
// scenarios add explicit expectations and a grant-order queue.
// ---------------------------------------------------------------------------
module tb_irq_priority_encoder;

  // ---------------- clock / reset / stimulus lines ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] mask = '0;
  logic        clr = 1'b0;
  logic        ready = 1'b0;

  always #5 clk = ~clk;

  logic        v0, v1, v2, v3;
  logic [3:0]  idx0, idx1, idx2;
  logic [2:0]  idx3;
  logic [15:0] pend0, pend1, pend2;
  logic [4:0]  pend3;

  irq_priority_encoder #(.N(16), .IDX_W(4), .ROUND_ROBIN(0), .EDGE(1)) u_fx (
    .CLK(clk), .RESET(rst), .REQ(req), .MASK(mask), .CLEAR_ALL(clr),
    .READY(ready), .VALID(v0), .INDEX(idx0), .PENDING(pend0));

  irq_priority_encoder #(.N(16), .IDX_W(4), .ROUND_ROBIN(1), .EDGE(1)) u_rr (
    .CLK(clk), .RESET(rst), .REQ(req), .MASK(mask), .CLEAR_ALL(clr),
    .READY(ready), .VALID(v1), .INDEX(idx1), .PENDING(pend1));

  irq_priority_encoder #(.N(16), .IDX_W(4), .ROUND_ROBIN(0), .EDGE(0)) u_lv (
    .CLK(clk), .RESET(rst), .REQ(req), .MASK(mask), .CLEAR_ALL(clr),
    .READY(ready), .VALID(v2), .INDEX(idx2), .PENDING(pend2));

  irq_priority_encoder #(.N(5), .IDX_W(3), .ROUND_ROBIN(1), .EDGE(0)) u_rr5 (
    .CLK(clk), .RESET(rst), .REQ(req[4:0]), .MASK(mask[4:0]), .CLEAR_ALL(clr),
    .READY(ready), .VALID(v3), .INDEX(idx3), .PENDING(pend3));

  logic        out_valid [4];
  logic [63:0] out_index [4];
  logic [63:0] out_pend  [4];

  assign out_valid[0] = v0;
  assign out_valid[1] = v1;
  assign out_valid[2] = v2;
  assign out_valid[3] = v3;
  assign out_index[0] = 64'(idx0);
  assign out_index[1] = 64'(idx1);
  assign out_index[2] = 64'(idx2);
  assign out_index[3] = 64'(idx3);
  assign out_pend[0]  = 64'(pend0);
  assign out_pend[1]  = 64'(pend1);
  assign out_pend[2]  = 64'(pend2);
  assign out_pend[3]  = 64'(pend3);

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  int          sb_inst  = -1;
  int          acc_cnt [4];

  // ---------------- reference model ----------------
  logic [15:0] m_pend  [4];
  logic [15:0] m_reqq  [4];
  logic        m_valid [4];
  int          m_index [4];
  int          m_last  [4];

  function automatic int cfg_n(input int m);
    return (m == 3) ? 5 : 16;
  endfunction

  function automatic bit cfg_rr(input int m);
    return (m == 1) || (m == 3);
  endfunction

  function automatic bit cfg_edge(input int m);
    return (m <= 1);
  endfunction

  // Fixed: lowest eligible index. Round robin: first eligible index met when
  // walking last+1, last+2, ... modulo n.
  function automatic int pick(input logic [15:0] elig, input int n, input bit rr,
                              input int last);
    if (rr) begin
      for (int off = 1; off <= n; off++) begin
        int j;
        j = (last + off) % n;
        if (elig[j]) return j;
      end
    end else begin
      for (int j = 0; j < n; j++) begin
        if (elig[j]) return j;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_pend[m]  = '0;
      m_reqq[m]  = '0;
      m_valid[m] = 1'b0;
      m_index[m] = 0;
      m_last[m]  = cfg_n(m) - 1;
    end
  endtask

  // Advance instance m by one clock using the inputs currently applied.
  task automatic model_step(input int m);
    int          n;
    logic [15:0] lim, r, set_v, elig, np;
    bit          nv;
    int          ni, nl;
    n     = cfg_n(m);
    lim   = 16'hFFFF >> (16 - n);
    r     = req & lim;
    set_v = cfg_edge(m) ? (r & ~m_reqq[m]) : r;
    elig  = m_pend[m] & ~mask & lim;
    np    = m_pend[m];
    nv    = m_valid[m];
    ni    = m_index[m];
    nl    = m_last[m];
    if (m_valid[m]) begin
      if (ready) begin
        nl = m_index[m];
        np[m_index[m]] = 1'b0;
      end
      if (ready || clr) nv = 1'b0;
    end else if ((elig != '0) && !clr) begin
      nv = 1'b1;
      ni = pick(elig, n, cfg_rr(m), m_last[m]);
    end
    np = np | set_v;
    if (clr) np = '0;
    m_reqq[m]  = r;
    m_pend[m]  = np;
    m_valid[m] = nv;
    m_index[m] = ni;
    m_last[m]  = nl;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic compare_all();
    for (int m = 0; m < 4; m++) begin
      check($sformatf("i%0d_valid", m), 64'(out_valid[m]), 64'(m_valid[m]));
      check($sformatf("i%0d_index", m), out_index[m], 64'(m_index[m]));
      check($sformatf("i%0d_pending", m), out_pend[m], 64'(m_pend[m]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with the next inputs applied.
  task automatic tick();
    logic [63:0] exp;
    for (int m = 0; m < 4; m++) begin
      if (out_valid[m] && ready) acc_cnt[m]++;
    end
    if (sb_inst >= 0 && out_valid[sb_inst] && ready) begin
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else                  exp = '1;
      check("sb_grant", out_index[sb_inst], exp);
    end
    for (int m = 0; m < 4; m++) model_step(m);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge.
  task automatic do_reset();
    #2;
    rst   = 1'b1;
    req   = '0;
    mask  = '0;
    clr   = 1'b0;
    ready = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    for (int m = 0; m < 4; m++) acc_cnt[m] = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    clear_counts();
    do_reset();

    // 1: single request, latency and acceptance
    req = 16'h0001;
    tick();
    check("t1_pending_set", out_pend[0], 64'h1);
    check("t1_valid_early", 64'(out_valid[0]), 64'h0);
    req = 16'h0000;
    tick();
    check("t1_valid", 64'(out_valid[0]), 64'h1);
    check("t1_index", out_index[0], 64'h0);
    ready = 1'b1;
    tick();
    check("t1_pending_clr", out_pend[0], 64'h0);
    check("t1_valid_drop", 64'(out_valid[0]), 64'h0);

    // 2: fixed priority, two simultaneous requests
    do_reset();
    exp_q.delete();
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd15);
    sb_inst = 0;
    ready   = 1'b1;
    req     = 16'h8001;
    tick();
    req = 16'h0000;
    for (int t = 0; t < 12 && exp_q.size() > 0; t++) tick();
    check("t2_all_grants", 64'(exp_q.size()), 64'h0);
    for (int t = 0; t < 4; t++) begin
      tick();
      check("t2_idle", 64'(out_valid[0]), 64'h0);
    end
    sb_inst = -1;

    // 3: round robin rotation with bits 1..3 constantly re-requested
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd2);
      exp_q.push_back(64'd3);
    end
    sb_inst = 1;
    ready   = 1'b1;
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) begin
      req = (t % 2 == 0) ? 16'h000E : 16'h0000;
      tick();
    end
    check("t3_all_grants", 64'(exp_q.size()), 64'h0);
    sb_inst = -1;
    req     = '0;
    ready   = 1'b0;

    // 4: masking at selection time, offer held after unmasking
    do_reset();
    req  = 16'h0003;
    mask = 16'h0001;
    tick();
    req = 16'h0000;
    tick();
    check("t4_valid", 64'(out_valid[0]), 64'h1);
    check("t4_index", out_index[0], 64'h1);
    mask = 16'h0000;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("t4_hold_valid", 64'(out_valid[0]), 64'h1);
      check("t4_hold_index", out_index[0], 64'h1);
    end
    ready = 1'b1;
    tick();
    check("t4_pending_after", out_pend[0], 64'h1);
    tick();
    check("t4_next_index", out_index[0], 64'h0);
    ready = 1'b0;

    // 5: held request, edge versus level triggering
    do_reset();
    clear_counts();
    req   = 16'h0010;
    ready = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    check("t5_edge_grants", 64'(acc_cnt[0]), 64'd1);
    check("t5_level_grants", 64'(acc_cnt[2]), 64'd4);
    req = 16'h0000;
    for (int t = 0; t < 4; t++) tick();
    ready = 1'b0;

    // 6: clear-all during an offer, then asynchronous reset during an offer
    do_reset();
    req = 16'h0004;
    tick();
    req = 16'h0000;
    tick();
    check("t6_offer", 64'(out_valid[0]), 64'h1);
    clr = 1'b1;
    tick();
    check("t6_clr_valid", 64'(out_valid[0]), 64'h0);
    check("t6_clr_pending", out_pend[0], 64'h0);
    clr = 1'b0;
    req = 16'h0020;
    tick();
    req = 16'h0000;
    tick();
    check("t6_offer2_index", out_index[0], 64'h5);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid[0]), 64'h0);
    check("t6_rst_index", out_index[0], 64'h0);
    check("t6_rst_pending", out_pend[0], 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model on all four instances
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        req   = 16'($urandom()) & 16'($urandom());
        mask  = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'h0000;
        ready = 1'($urandom_range(0, 1));
        clr   = ($urandom_range(0, 29) == 0);
        tick();
      end
    end
    req   = '0;
    mask  = '0;
    clr   = 1'b0;
    ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
Parametrised, registered priority encoder that collects request lines into a pending register and selects one eligible request. It presents the selected index over a valid/ready handshake. Fixed-priority or round-robin selection is chosen at elaboration time. It serves as the interrupt/event arbiter front-end of the core and succeeds the fixed-width combinational Encoder_4/8/16 set.

Parameters:
N, 16, number of request inputs (2..64).
IDX_W, 4, index width; must equal ceil(log2(N)).
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last granted index.
EDGE, 1, 1 = a rising edge of REQ sets pending; 0 = a level-high REQ sets pending every cycle.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RESET  in  1  asynchronous reset, active-high.
REQ  in  N  request lines, synchronous to CLK.
MASK  in  N  1 = request excluded from selection; the pending bit is still recorded.
CLEAR_ALL  in  1  synchronous clear of all pending bits.
READY  in  1  consumer accepts the offered index.
VALID  out  1  INDEX is valid and offered.
INDEX  out  IDX_W  selected request index.
PENDING  out  N  pending register, direct view.

Behaviour:
- Reset (async, any time, including mid-offer):
  - PENDING=0, VALID=0, INDEX=0, req_q=0.
  - Round-robin pointer last=N-1, so the first search starts at index 0.
  - FSM goes to IDLE.
- Edge detect: req_q <= REQ each cycle. set = EDGE ? (REQ & ~req_q) : REQ.
- Pending update, per bit, in priority order:
  - CLEAR_ALL → 0.
  - else set → 1.
  - else accepted-grant of this bit → 0.
  - So a new set in the same cycle as its own acceptance keeps the bit pending.
- Eligible vector: elig = PENDING & ~MASK, using the registered PENDING.
- Fixed mode: pick the lowest set index of elig.
- Round-robin mode: pick the first set index scanning last+1, last+2, … wrapping modulo N. On acceptance, last <= INDEX.
- FSM IDLE:
  - If elig!=0 and CLEAR_ALL=0: INDEX <= pick, VALID <= 1, go to OFFER.
  - Else stay in IDLE with VALID=0 and INDEX holding its last value.
- FSM OFFER (VALID=1):
  - INDEX and VALID are held stable until accepted. A higher-priority arrival or masking the offered bit does not change the offer.
  - VALID & READY: accept; clear PENDING[INDEX]; VALID <= 0; go to IDLE.
  - CLEAR_ALL (with or without READY): VALID <= 0; go to IDLE. If READY was also high, the grant still counts for the round-robin pointer.
- Timing:
  - Minimum one VALID-low cycle between consecutive grants, so the max throughput is one grant per 2 cycles.
  - Latency: REQ rises at edge t → PENDING set at t+1 → VALID high at t+2.
- READY while VALID=0 is ignored.
- Bits of PENDING at index ≥ N do not exist. INDEX never exceeds N-1.

Test Plan:
1. Reset then REQ=0x0001 for one cycle → PENDING=0x0001 next cycle, VALID=1/INDEX=0 the cycle after. READY=1 → PENDING=0x0000, VALID=0.
2. Fixed mode, REQ=0x8001 rising together, READY held 1 → grants INDEX=0, then INDEX=15 two cycles later, then VALID stays 0.
3. ROUND_ROBIN=1, REQ edges on bits 1, 2 and 3 re-pulsed after every grant, READY=1 → INDEX sequence 1,2,3,1,2,3; bit 0 never granted.
4. MASK=0x0001 with pending 0x0003 → INDEX=1. Then MASK=0x0000 while offering 1 with READY=0 → INDEX stays 1 until READY.
5. EDGE=1, REQ held high 10 cycles → exactly one grant. EDGE=0, same stimulus → a grant every 2 cycles while READY=1.
6. Asserting CLEAR_ALL during OFFER → next cycle VALID=0, PENDING=0. Asserting RESET mid-offer (async, between edges) → VALID=0 and INDEX=0 immediately.
